// File: rtl/xc_malu_pkg.sv
// Shared definitions for the xc_malu divider path.
//   - Divider FSM state encodings (IDLE/RUN/DONE), kept as plain 2-bit
//     constants so that existing xc_malu code can still compare against them.
//   - cnt_width(): width of the step counter for a W-bit divider.
package xc_malu_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // The counter has to hold W-1, so $clog2(W) bits are enough for any W >= 2.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/xc_malu_divstep.sv
// One radix-2 restoring division step (purely combinational).
//   rem     in  W  partial remainder (always < dvs)
//   dvd     in  W  dividend shift register; quotient bits enter at the LSB
//   dvs     in  W  divisor magnitude
//   rem_nxt out W  partial remainder after the step
//   dvd_nxt out W  dividend/quotient register after the step
module xc_malu_divstep #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvd,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] dvd_nxt
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // Because rem < dvs holds between steps, the true trial value lies in
  // [-dvs, dvs-1], so W+1 bits are enough and trial[W] is its sign.
  always_comb begin
    shifted = {rem, dvd[W-1]};
    trial   = shifted - {1'b0, dvs};
    if (trial[W]) begin
      rem_nxt = shifted[W-1:0];
    end else begin
      rem_nxt = trial[W-1:0];
    end
    dvd_nxt = {dvd[W-2:0], ~trial[W]};
  end

endmodule

// File: rtl/xc_malu_divrem.sv
// Multi-cycle W-bit divide/remainder unit (radix-2 restoring) with
// RISC-V M semantics and early-out for divide-by-zero and signed overflow.
//   clock     in   1  system clock
//   resetn    in   1  asynchronous active-low reset
//   flush     in   1  abandon / retire the current operation
//   valid     in   1  operands valid, held until ready
//   rs1       in   W  dividend
//   rs2       in   W  divisor
//   mod_sign  in   1  operands are two's-complement signed
//   ready     out  1  result_q/result_r valid
//   busy      out  1  iterating (RUN state)
//   result_q  out  W  quotient
//   result_r  out  W  remainder
module xc_malu_divrem
  import xc_malu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         flush,
  input  logic         valid,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  input  logic         mod_sign,
  output logic         ready,
  output logic         busy,
  output logic [W-1:0] result_q,
  output logic [W-1:0] result_r
);

  localparam int unsigned CW = cnt_width(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  rem_q,   rem_d;
  logic [W-1:0]  dvd_q,   dvd_d;
  logic [W-1:0]  dvs_q,   dvs_d;
  logic          negq_q,  negq_d;
  logic          negr_q,  negr_d;
  logic [W-1:0]  quo_q,   quo_d;
  logic [W-1:0]  rmd_q,   rmd_d;

  logic [W-1:0]  rs1_abs;
  logic [W-1:0]  rs2_abs;
  logic [W-1:0]  rem_nxt;
  logic [W-1:0]  dvd_nxt;

  xc_malu_divstep #(
    .W (W)
  ) u_step (
    .rem     (rem_q),
    .dvd     (dvd_q),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .dvd_nxt (dvd_nxt)
  );

  always_comb begin
    rs1_abs = (mod_sign && rs1[W-1]) ? -rs1 : rs1;
    rs2_abs = (mod_sign && rs2[W-1]) ? -rs2 : rs2;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    case (state_q)
      IDLE: begin
        if (valid && !flush) begin
          if (rs2 == '0) begin
            quo_d   = '1;
            rmd_d   = rs1;
            state_d = DONE;
          end else if (mod_sign && (rs1 == MIN_NEG) && (rs2 == '1)) begin
            quo_d   = rs1;
            rmd_d   = '0;
            state_d = DONE;
          end else begin
            dvd_d   = rs1_abs;
            dvs_d   = rs2_abs;
            rem_d   = '0;
            cnt_d   = CW'(W - 1);
            negq_d  = mod_sign & (rs1[W-1] ^ rs2[W-1]);
            negr_d  = mod_sign & rs1[W-1];
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (flush || !valid) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nxt;
          dvd_d = dvd_nxt;
          if (cnt_q == '0) begin
            // Sign correction is applied to the final step's outputs so the
            // results are registered on the same edge that enters DONE.
            quo_d   = negq_q ? -dvd_nxt : dvd_nxt;
            rmd_d   = negr_q ? -rem_nxt : rem_nxt;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      DONE: begin
        if (flush || !valid) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  assign ready    = (state_q == DONE);
  assign busy     = (state_q == RUN);
  assign result_q = quo_q;
  assign result_r = rmd_q;

endmodule
